pll_lock_seq: RTL

- Reset/lock sequencer for the video PLL: 27 MHz in, 74.25 MHz pixel clock and 371.25 MHz serial clock out.
- Runs on the free-running 27 MHz input clock and drives the PLL RESET and PLLPWD pins.
- Qualifies LOCK and releases the downstream video-domain reset only after lock has been stable.
- On lock loss, restarts the PLL automatically and keeps a relock count plus a sticky timeout flag for the system controller.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 22 ++
 rtl/pll_lock_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL lock sequencer.
// Holds the FSM state enum, relock saturation value and a width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    PWRDN     = 3'd4
  } state_t;

  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // Width of a counter able to reach the largest of three limits.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchronizer for a PLL LOCK pin.
// Ports: clk, rst_n (async active-low), d (async in), q (synced out).
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: reset/lock sequencer for the video PLL on the 27 MHz clock.
// Ports: clk, resetn, pll_lock, restart, pwd_req, clr_err in;
//        pll_reset, pll_pwd, ready, relock_cnt, timeout_err out.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 32,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 270000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       restart,
  input  logic       pwd_req,
  input  logic       clr_err,
  output logic       pll_reset,
  output logic       pll_pwd,
  output logic       ready,
  output logic [7:0] relock_cnt,
  output logic       timeout_err
);

  localparam int CW =
    cnt_width(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [7:0]    relock_nx;
  logic          terr_nx;
  logic          enter;
  logic          lock_s;

  pll_lock_sync u_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nx  = state;
    enter     = 1'b0;
    relock_nx = relock_cnt;
    terr_nx   = timeout_err;
    // Clear first so a coincident event still lands on top of it.
    if (clr_err) begin
      relock_nx = '0;
      terr_nx   = 1'b0;
    end
    if (pwd_req) begin
      state_nx = PWRDN;
      enter    = (state != PWRDN);
    end else if (state == PWRDN) begin
      state_nx = RESET_PLL;
      enter    = 1'b1;
    end else if (restart) begin
      state_nx = RESET_PLL;
      enter    = 1'b1;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nx = WAIT_LOCK;
            enter    = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = STABLE;
            enter    = 1'b1;
          end else if (cnt == TO_LAST) begin
            state_nx = RESET_PLL;
            enter    = 1'b1;
            terr_nx  = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nx = WAIT_LOCK;
            enter    = 1'b1;
          end else if (cnt == STB_LAST) begin
            state_nx = RUN;
            enter    = 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nx = RESET_PLL;
            enter    = 1'b1;
            if (relock_nx != RELOCK_MAX)
              relock_nx = relock_nx + 8'd1;
          end
        end
        default: begin
          state_nx = RESET_PLL;
          enter    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cnt_nx = cnt;
    if (enter)
      cnt_nx = '0;
    else if (state == RESET_PLL ||
             state == WAIT_LOCK ||
             state == STABLE)
      cnt_nx = cnt + CW'(1);
  end

  // Outputs are decoded from the next state so the pins come
  // straight off flops and track the state register exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      relock_cnt  <= '0;
      timeout_err <= 1'b0;
      ready       <= 1'b0;
      pll_reset   <= 1'b1;
      pll_pwd     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      relock_cnt  <= relock_nx;
      timeout_err <= terr_nx;
      ready       <= (state_nx == RUN);
      pll_reset   <= (state_nx == RESET_PLL) ||
                     (state_nx == PWRDN);
      pll_pwd     <= (state_nx == PWRDN);
    end
  end

endmodule
